spi_slave_sync: RTL and testbench

//  Clock-domain front end for the MCU SPI port: oversamples CLK/CS/MOSI/SPECIAL in the XTALCLK domain.

---
 rtl/spi_slave_sync_pkg.sv | 27 ++
 rtl/spi_slave_sync_sync_edge.sv | 33 +++
 rtl/spi_slave_sync.sv | 169 ++++++++++++++++
 tb/tb_spi_slave_sync.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_sync_pkg.sv
// Shared definitions for the SPI slave front end: FSM encodings, idle levels
// of the raw SPI pins and the saturating bit-counter helper.
`timescale 1ns/1ps
package spi_slave_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int MSB_DEFAULT = 16;

    // Levels the raw pins rest at between frames; synchronisers reset to these.
    localparam logic CS_IDLE      = 1'b1;
    localparam logic SPECIAL_IDLE = 1'b1;
    localparam logic CLK_IDLE     = 1'b0;
    localparam logic MOSI_IDLE    = 1'b0;

    localparam int                  BITCNT_W   = 8;
    localparam logic [BITCNT_W-1:0] BITCNT_MAX = {BITCNT_W{1'b1}};

    function automatic logic [BITCNT_W-1:0] sat_inc(input logic [BITCNT_W-1:0] v);
        return (v == BITCNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/spi_slave_sync_sync_edge.sv
// Multi-flop synchroniser with rise/fall detection on the synchronised level.
// Resets to the pin's idle level so a quiet bus produces no spurious edges.
`timescale 1ns/1ps
module spi_slave_sync_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_slave_sync.sv
// SPI mode-1 slave oversampled in the system clock domain: deserialises
// special-mode frames into rx_word/rx_valid and shifts tx_word out on MISO.
`timescale 1ns/1ps
module spi_slave_sync
    import spi_slave_sync_pkg::*;
#(
    parameter int MSB         = MSB_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           spi_clk,
    input  logic           spi_cs,
    input  logic           spi_mosi,
    input  logic           spi_special,
    output logic           spi_miso,
    input  logic [MSB-1:0] tx_word,
    output logic [MSB-1:0] rx_word,
    output logic           rx_valid,
    output logic           frame_err,
    output logic           busy
);

    localparam logic [BITCNT_W-1:0] MSB_CNT    = BITCNT_W'(MSB);
    localparam logic [BITCNT_W-1:0] SETTLE_CNT = BITCNT_W'(SYNC_STAGES + 1);

    logic clk_lvl, clk_rise, clk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic special_lvl, special_rise_unused, special_fall_unused;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

    spi_slave_sync_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CLK_IDLE)) u_sync_clk (
        .clk   (clk),
        .rst   (rst),
        .din   (spi_clk),
        .level (clk_lvl),
        .rise  (clk_rise),
        .fall  (clk_fall)
    );

    spi_slave_sync_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CS_IDLE)) u_sync_cs (
        .clk   (clk),
        .rst   (rst),
        .din   (spi_cs),
        .level (cs_lvl),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_slave_sync_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SPECIAL_IDLE)) u_sync_special (
        .clk   (clk),
        .rst   (rst),
        .din   (spi_special),
        .level (special_lvl),
        .rise  (special_rise_unused),
        .fall  (special_fall_unused)
    );

    spi_slave_sync_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(MOSI_IDLE)) u_sync_mosi (
        .clk   (clk),
        .rst   (rst),
        .din   (spi_mosi),
        .level (mosi_lvl),
        .rise  (mosi_rise_unused),
        .fall  (mosi_fall_unused)
    );

    // The synchronisers reset to CS high, so a CS still low at reset release
    // looks like a falling edge. Frames are only accepted once CS has been
    // seen high after the chain holds real samples.
    logic [BITCNT_W-1:0] settle_cnt;
    logic                armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= SETTLE_CNT;
            armed      <= 1'b0;
        end else if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - 1'b1;
        end else if (cs_lvl == CS_IDLE) begin
            armed <= 1'b1;
        end
    end

    state_t state_q, state_d;
    logic   start, shift_in, shift_out, finish;
    logic   frame_sel;

    assign frame_sel = armed && cs_fall && (special_lvl != SPECIAL_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (frame_sel) state_d = ST_ACTIVE;
            ST_ACTIVE: if (cs_rise)   state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // A CS rise in the same cycle as an SCLK edge ends the frame; the clock edge is dropped.
    always_comb begin
        start     = 1'b0;
        shift_in  = 1'b0;
        shift_out = 1'b0;
        finish    = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: start = frame_sel;
            ST_ACTIVE: begin
                busy      = 1'b1;
                shift_in  = clk_fall && !cs_rise;
                shift_out = clk_rise && !cs_rise;
            end
            ST_DONE: finish = 1'b1;
            default: ;
        endcase
    end

    logic [MSB-1:0]      rx_shift;
    logic [MSB-1:0]      tx_shift;
    logic [BITCNT_W-1:0] bitcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_shift  <= '0;
            tx_shift  <= '0;
            bitcnt    <= '0;
            rx_word   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            spi_miso  <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (start) begin
                tx_shift <= tx_word;
                rx_shift <= '0;
                bitcnt   <= '0;
            end
            if (shift_in) begin
                rx_shift <= {rx_shift[MSB-2:0], mosi_lvl};
                bitcnt   <= sat_inc(bitcnt);
            end
            if (shift_out) begin
                spi_miso <= tx_shift[MSB-1];
                tx_shift <= {tx_shift[MSB-2:0], 1'b0};
            end
            if (finish) begin
                spi_miso <= 1'b0;
                if (bitcnt == MSB_CNT) begin
                    rx_word  <= rx_shift;
                    rx_valid <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed and randomized bench for spi_slave_sync: raw SPI stimulus from a
// behavioural master, expectations from a frame-level model.
`timescale 1ns/1ps
module tb_spi_slave_sync;

    localparam int MSB  = 16;
    localparam int SYNC = 2;
    localparam int SLOW = 80;

    logic           clk = 1'b0;
    logic           rst;
    logic           spi_clk, spi_cs, spi_mosi, spi_special;
    logic           spi_miso;
    logic [MSB-1:0] tx_word;
    logic [MSB-1:0] rx_word;
    logic           rx_valid, frame_err, busy;

    int total = 0;
    int bad   = 0;

    // observed events
    logic [MSB-1:0] rxq[$];
    int             err_cnt = 0;
    int             consec  = 0;
    bit             busy_seen = 0;
    bit             miso_seen = 0;
    bit             prev_valid = 0;

    // frame-level reference model
    logic [MSB-1:0] exp_words[$];
    int             exp_errs = 0;
    logic [MSB-1:0] exp_last = '0;

    always #5 clk = ~clk;

    spi_slave_sync #(.MSB(MSB), .SYNC_STAGES(SYNC)) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_clk     (spi_clk),
        .spi_cs      (spi_cs),
        .spi_mosi    (spi_mosi),
        .spi_special (spi_special),
        .spi_miso    (spi_miso),
        .tx_word     (tx_word),
        .rx_word     (rx_word),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 0;
        end else begin
            if (rx_valid) begin
                rxq.push_back(rx_word);
                if (prev_valid) consec++;
            end
            if (frame_err) err_cnt++;
            if (busy) busy_seen = 1;
            if (spi_miso) miso_seen = 1;
            prev_valid = rx_valid;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: a special frame of exactly MSB bits yields its word, any other length an error.
    task automatic model_frame(input logic [31:0] bits, input int n, input logic special);
        if (special == 1'b0) begin
            if (n == MSB) begin
                exp_words.push_back(bits[MSB-1:0]);
                exp_last = bits[MSB-1:0];
            end else begin
                exp_errs++;
            end
        end
    endtask

    task automatic clock_bits(input logic [31:0] bits, input int n, input int half,
                              output logic [MSB-1:0] miso_bits);
        miso_bits = '0;
        for (int i = 0; i < n; i++) begin
            spi_mosi = bits[n-1-i];
            spi_clk  = 1'b1;
            #(half);
            miso_bits = {miso_bits[MSB-2:0], spi_miso};
            spi_clk = 1'b0;
            #(half);
        end
    endtask

    task automatic send_frame(input logic [31:0] bits, input int n, input logic special,
                              output logic [MSB-1:0] miso_bits);
        spi_special = special;
        spi_cs      = 1'b0;
        #(SLOW);
        clock_bits(bits, n, SLOW, miso_bits);
        spi_cs = 1'b1;
        model_frame(bits, n, special);
    endtask

    task automatic clear_obs();
        rxq.delete();
        exp_words.delete();
        err_cnt   = 0;
        exp_errs  = 0;
        consec    = 0;
        busy_seen = 0;
        miso_seen = 0;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_count"}, rxq.size(), exp_words.size());
        for (int i = 0; i < rxq.size() && i < exp_words.size(); i++)
            check({tag, "_word"}, rxq[i], exp_words[i]);
        check({tag, "_errs"}, err_cnt, exp_errs);
        check({tag, "_rx_word"}, rx_word, exp_last);
        check({tag, "_consec"}, consec, 0);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MSB-1:0] mb;
        logic [31:0]    w;
        int             lat;
        int             h;

        rst = 1'b1; spi_clk = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;
        spi_special = 1'b1; tx_word = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_word",   rx_word,   0);
        check("rst_rx_valid",  rx_valid,  0);
        check("rst_frame_err", frame_err, 0);
        check("rst_busy",      busy,      0);
        check("rst_miso",      spi_miso,  0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // 1: basic special frame, latency and MISO readback
        clear_obs();
        tx_word = 16'hFF00;
        send_frame(32'h0731, 16, 1'b0, mb);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (rx_valid) begin
                lat = k;
                break;
            end
        end
        check("t1_latency", lat, SYNC + 2);
        check("t1_rx_word_at_valid", rx_word, 16'h0731);
        check("t1_miso", mb, 16'hFF00);
        repeat (10) @(posedge clk); #1;
        check("t1_busy_seen", busy_seen, 1);
        check_model("t1");

        // 2: short and long frames
        clear_obs();
        w = $urandom;
        send_frame(w, 15, 1'b0, mb);
        repeat (10) @(posedge clk); #1;
        w = $urandom;
        send_frame(w, 17, 1'b0, mb);
        repeat (10) @(posedge clk); #1;
        check_model("t2");

        // 3: non-special frame is ignored
        clear_obs();
        tx_word = 16'hFFFF;
        send_frame(32'h0B00, 16, 1'b1, mb);
        repeat (10) @(posedge clk); #1;
        check("t3_busy_seen", busy_seen, 0);
        check("t3_miso_seen", miso_seen, 0);
        check_model("t3");

        // 4: reset in the middle of a frame, CS still low at release
        clear_obs();
        tx_word = 16'h0000;
        spi_special = 1'b0;
        spi_cs = 1'b0;
        #(SLOW);
        clock_bits(32'hA5, 8, SLOW, mb);
        rst = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("t4_rst_busy", busy, 0);
        check("t4_rst_rx_word", rx_word, 0);
        exp_last = '0;
        rst = 1'b0;
        clock_bits(32'h3C, 8, SLOW, mb);
        spi_cs = 1'b1;
        repeat (10) @(posedge clk); #1;
        check("t4_no_strobe", rxq.size() + err_cnt, 0);
        send_frame(32'h0A07, 16, 1'b0, mb);
        repeat (10) @(posedge clk); #1;
        check_model("t4");

        // 5: back-to-back frames with the minimum gap
        clear_obs();
        send_frame(32'h0803, 16, 1'b0, mb);
        #20;
        send_frame(32'h08F0, 16, 1'b0, mb);
        repeat (10) @(posedge clk); #1;
        check_model("t5");

        // 6: fast SCLK with jittered edges, random words
        clear_obs();
        spi_special = 1'b0;
        @(posedge clk); #0.5;
        for (int f = 0; f < 1000; f++) begin
            w = $urandom;
            tx_word = 16'($urandom);
            spi_cs = 1'b0;
            #(20 + $urandom_range(0, 2));
            for (int i = 0; i < MSB; i++) begin
                spi_mosi = w[MSB-1-i];
                spi_clk  = 1'b1;
                h = 20 + $urandom_range(0, 2);
                #(h);
                spi_clk = 1'b0;
                h = 20 + $urandom_range(0, 2);
                #(h);
            end
            spi_cs = 1'b1;
            model_frame(w, MSB, 1'b0);
            #(30 + $urandom_range(0, 2));
        end
        repeat (20) @(posedge clk); #1;
        check_model("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
